// File: rtl/irq_sequencer_if.sv
// Memory-bus bundle the interrupt sequencer drives while it owns the bus.
// The master side is the sequencer; the slave side is the memory/bus fabric.
interface irq_sequencer_if;
  logic        seq_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport master (
    output seq_busy, mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport slave (
    input  seq_busy, mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/irq_sequencer.sv
// 6502 reset/NMI/IRQ/BRK sequencer: pushes PC and P, fetches the vector, issues a PC load.
// Optional macro NMI_HIJACK_EN lets a pending NMI steal the vector of an IRQ/BRK during the P push.
module irq_sequencer #(
  parameter logic [15:0] VEC_NMI = 16'hFFFA,
  parameter logic [15:0] VEC_RST = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  nmi_n,
  input  logic                  irq_n,
  input  logic                  brk_req,
  input  logic                  insn_boundary,
  input  logic [7:0]            p_in,
  input  logic [7:0]            pch_in,
  input  logic [7:0]            pcl_in,
  input  logic [7:0]            s_in,
  irq_sequencer_if.master       bus,
  output logic                  s_dec,
  output logic                  pc_ld,
  output logic [15:0]           pc_val,
  output logic                  set_i,
  output logic                  irq_ack,
  output logic [1:0]            irq_cause
);

  localparam logic [1:0] CAUSE_RST = 2'b00;
  localparam logic [1:0] CAUSE_NMI = 2'b01;
  localparam logic [1:0] CAUSE_IRQ = 2'b10;
  localparam logic [1:0] CAUSE_BRK = 2'b11;

  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_LOAD
  } state_t;

  state_t      state_reg, state_next;
  logic        nmi_q_reg;
  logic        nmi_pending_reg, nmi_pending_next;
  logic        nmi_clr;
  logic [1:0]  cause_reg, cause_next;
  logic [15:0] vector_reg, vector_next;
  logic        b_reg, b_next;
  logic [7:0]  pch_reg, pch_next;
  logic [7:0]  pcl_reg, pcl_next;
  logic [7:0]  sp_reg, sp_next;
  logic [15:0] pc_val_reg, pc_val_next;
  logic        irq_take;

  assign irq_take = ~irq_n & ~p_in[2];
  assign pc_val   = pc_val_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_RST;
      nmi_q_reg       <= 1'b1;
      nmi_pending_reg <= 1'b0;
      cause_reg       <= CAUSE_RST;
      vector_reg      <= VEC_RST;
      b_reg           <= 1'b0;
      pch_reg         <= 8'h00;
      pcl_reg         <= 8'h00;
      sp_reg          <= 8'h00;
      pc_val_reg      <= 16'h0000;
    end else begin
      state_reg       <= state_next;
      nmi_q_reg       <= nmi_n;
      nmi_pending_reg <= nmi_pending_next;
      cause_reg       <= cause_next;
      vector_reg      <= vector_next;
      b_reg           <= b_next;
      pch_reg         <= pch_next;
      pcl_reg         <= pcl_next;
      sp_reg          <= sp_next;
      pc_val_reg      <= pc_val_next;
    end
  end

  // A fresh falling edge wins over a clear in the same cycle: it is a new request.
  assign nmi_pending_next = (nmi_pending_reg & ~nmi_clr) | (nmi_q_reg & ~nmi_n);

  always_comb begin
    state_next    = state_reg;
    cause_next    = cause_reg;
    vector_next   = vector_reg;
    b_next        = b_reg;
    pch_next      = pch_reg;
    pcl_next      = pcl_reg;
    sp_next       = sp_reg;
    pc_val_next   = pc_val_reg;
    nmi_clr       = 1'b0;
    bus.seq_busy  = 1'b1;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 8'h00;
    bus.mem_we    = 1'b0;
    s_dec         = 1'b0;
    pc_ld         = 1'b0;
    set_i         = 1'b0;
    irq_ack       = 1'b0;
    irq_cause     = 2'b00;

    case (state_reg)
      S_RST: begin
        bus.mem_addr = VEC_RST;
        vector_next  = VEC_RST;
        cause_next   = CAUSE_RST;
        state_next   = S_VEC_LO;
      end
      S_IDLE: begin
        bus.seq_busy = 1'b0;
        if (insn_boundary && (nmi_pending_reg || irq_take || brk_req)) begin
          state_next = S_PUSH_PCH;
          pch_next   = pch_in;
          pcl_next   = pcl_in;
          sp_next    = s_in;
          if (nmi_pending_reg) begin
            cause_next  = CAUSE_NMI;
            vector_next = VEC_NMI;
            b_next      = 1'b0;
            nmi_clr     = 1'b1;
          end else if (irq_take) begin
            cause_next  = CAUSE_IRQ;
            vector_next = VEC_IRQ;
            b_next      = 1'b0;
          end else begin
            cause_next  = CAUSE_BRK;
            vector_next = VEC_IRQ;
            b_next      = 1'b1;
          end
        end
      end
      S_PUSH_PCH: begin
        bus.mem_addr  = {8'h01, sp_reg};
        bus.mem_wdata = pch_reg;
        bus.mem_we    = 1'b1;
        s_dec         = 1'b1;
        sp_next       = sp_reg - 8'd1;
        state_next    = S_PUSH_PCL;
      end
      S_PUSH_PCL: begin
        bus.mem_addr  = {8'h01, sp_reg};
        bus.mem_wdata = pcl_reg;
        bus.mem_we    = 1'b1;
        s_dec         = 1'b1;
        sp_next       = sp_reg - 8'd1;
        state_next    = S_PUSH_P;
      end
      S_PUSH_P: begin
        bus.mem_addr  = {8'h01, sp_reg};
        bus.mem_wdata = {p_in[7:6], 1'b1, b_reg, p_in[3:0]};
        bus.mem_we    = 1'b1;
        s_dec         = 1'b1;
        sp_next       = sp_reg - 8'd1;
        state_next    = S_VEC_LO;
`ifdef NMI_HIJACK_EN
        // B bit already went out on the bus above, so it keeps the original cause.
        if (((cause_reg == CAUSE_IRQ) || (cause_reg == CAUSE_BRK)) && nmi_pending_reg) begin
          vector_next = VEC_NMI;
          cause_next  = CAUSE_NMI;
          nmi_clr     = 1'b1;
        end
`endif
      end
      S_VEC_LO: begin
        bus.mem_addr     = vector_reg;
        pc_val_next[7:0] = bus.mem_rdata;
        state_next       = S_VEC_HI;
      end
      S_VEC_HI: begin
        bus.mem_addr      = vector_reg + 16'd1;
        pc_val_next[15:8] = bus.mem_rdata;
        state_next        = S_LOAD;
      end
      S_LOAD: begin
        pc_ld      = 1'b1;
        set_i      = 1'b1;
        irq_ack    = 1'b1;
        irq_cause  = cause_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: expected bus writes and PC loads are queued as stimulus
// is applied and checked by a negedge monitor as the sequencer produces them.
module tb_irq_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nmi_n = 1'b1;
  logic        irq_n = 1'b1;
  logic        brk_req = 1'b0;
  logic        insn_boundary = 1'b0;
  logic [7:0]  p_in = 8'h00;
  logic [7:0]  pch_in = 8'h00;
  logic [7:0]  pcl_in = 8'h00;
  logic [7:0]  s_in = 8'h00;
  logic        s_dec, pc_ld, set_i, irq_ack;
  logic [15:0] pc_val;
  logic [1:0]  irq_cause;
  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_load;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [1:0]  cause;
  } ev_t;
  ev_t exp_q[$];

  irq_sequencer_if bus();

  irq_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .nmi_n         (nmi_n),
    .irq_n         (irq_n),
    .brk_req       (brk_req),
    .insn_boundary (insn_boundary),
    .p_in          (p_in),
    .pch_in        (pch_in),
    .pcl_in        (pcl_in),
    .s_in          (s_in),
    .bus           (bus),
    .s_dec         (s_dec),
    .pc_ld         (pc_ld),
    .pc_val        (pc_val),
    .set_i         (set_i),
    .irq_ack       (irq_ack),
    .irq_cause     (irq_cause)
  );

  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e = '{is_load: 1'b0, addr: a, data: d, cause: 2'b00};
    exp_q.push_back(e);
  endtask

  task automatic push_ld(input logic [15:0] pc, input logic [1:0] c);
    ev_t e;
    e = '{is_load: 1'b1, addr: pc, data: 8'h00, cause: c};
    exp_q.push_back(e);
  endtask

  // Step clocks until pc_ld, optionally pulsing nmi_n low for one cycle after edge nmi_at.
  task automatic run_seq(input int exp_n, input int nmi_at, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      insn_boundary = 1'b0;
      nmi_n = (n == nmi_at) ? 1'b0 : 1'b1;
    end while (pc_ld !== 1'b1 && n < 40);
    chk({tag, "_latency"}, n, exp_n);
    @(posedge clk); #1;
    nmi_n = 1'b1;
    chk({tag, "_idle_after"}, {31'd0, bus.seq_busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.mem_we || s_dec || pc_ld)) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event: observed addr %h we %b pc_ld %b expected no event",
               bus.mem_addr, bus.mem_we, pc_ld);
      end
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        if (!e.is_load) begin
          chk("wr_we", {31'd0, bus.mem_we}, 32'd1);
          chk("wr_s_dec", {31'd0, s_dec}, 32'd1);
          chk("wr_addr", {16'd0, bus.mem_addr}, {16'd0, e.addr});
          chk("wr_data", {24'd0, bus.mem_wdata}, {24'd0, e.data});
        end else begin
          chk("ld_pc_ld", {31'd0, pc_ld}, 32'd1);
          chk("ld_set_i_ack", {30'd0, set_i, irq_ack}, 32'd3);
          chk("ld_we", {31'd0, bus.mem_we}, 32'd0);
          chk("ld_pc_val", {16'd0, pc_val}, {16'd0, e.addr});
          chk("ld_cause", {30'd0, irq_cause}, {30'd0, e.cause});
        end
      end
    end
  end

  initial begin
    mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hAB;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h78; mem[16'hFFFF] = 8'h9A;

    // Reset state and reset sequence.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.seq_busy}, 32'd1);
    chk("rst_addr", {16'd0, bus.mem_addr}, 32'h0000FFFC);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_pulses", {28'd0, s_dec, pc_ld, set_i, irq_ack}, 32'd0);
    chk("rst_pc_val", {16'd0, pc_val}, 32'd0);
    chk("rst_cause", {30'd0, irq_cause}, 32'd0);
    rst_n = 1'b1;
    push_ld(16'h1234, 2'b00);
    run_seq(3, 0, "reset");

    // Unmasked IRQ.
    s_in = 8'hFF; pch_in = 8'h04; pcl_in = 8'h56; p_in = 8'h20; irq_n = 1'b0;
    push_wr(16'h01FF, 8'h04); push_wr(16'h01FE, 8'h56); push_wr(16'h01FD, 8'h20);
    push_ld(16'h9A78, 2'b10);
    insn_boundary = 1'b1;
    run_seq(6, 0, "irq");
    irq_n = 1'b1;

    // Masked IRQ with BRK pending: BRK is taken.
    s_in = 8'hF0; pch_in = 8'h12; pcl_in = 8'h02; p_in = 8'h24; irq_n = 1'b0; brk_req = 1'b1;
    push_wr(16'h01F0, 8'h12); push_wr(16'h01EF, 8'h02); push_wr(16'h01EE, 8'h34);
    push_ld(16'h9A78, 2'b11);
    insn_boundary = 1'b1;
    run_seq(6, 0, "brk");
    brk_req = 1'b0; irq_n = 1'b1;

    // NMI pulse while an IRQ is in its vector fetch; served at the next boundary.
    s_in = 8'hFD; pch_in = 8'h03; pcl_in = 8'h00; p_in = 8'h20; irq_n = 1'b0;
    push_wr(16'h01FD, 8'h03); push_wr(16'h01FC, 8'h00); push_wr(16'h01FB, 8'h20);
    push_ld(16'h9A78, 2'b10);
    insn_boundary = 1'b1;
    run_seq(6, 4, "irq_nmi");
    irq_n = 1'b1;
    s_in = 8'hFA; pch_in = 8'h04; pcl_in = 8'h00; p_in = 8'h20;
    push_wr(16'h01FA, 8'h04); push_wr(16'h01F9, 8'h00); push_wr(16'h01F8, 8'h20);
    push_ld(16'hABCD, 2'b01);
    insn_boundary = 1'b1;
    run_seq(6, 0, "nmi");

    // NMI edge during PUSH_PCL of a BRK.
    s_in = 8'hE0; pch_in = 8'h50; pcl_in = 8'h05; p_in = 8'h20; brk_req = 1'b1;
    push_wr(16'h01E0, 8'h50); push_wr(16'h01DF, 8'h05); push_wr(16'h01DE, 8'h30);
`ifdef NMI_HIJACK_EN
    push_ld(16'hABCD, 2'b01);
    insn_boundary = 1'b1;
    run_seq(6, 2, "brk_hijack");
    brk_req = 1'b0;
    insn_boundary = 1'b1;
    @(posedge clk); #1;
    insn_boundary = 1'b0;
    chk("hijack_nmi_consumed", {31'd0, bus.seq_busy}, 32'd0);
`else
    push_ld(16'h9A78, 2'b11);
    insn_boundary = 1'b1;
    run_seq(6, 2, "brk_nmi_wait");
    brk_req = 1'b0;
    s_in = 8'hDD; pch_in = 8'h60; pcl_in = 8'h00; p_in = 8'h20;
    push_wr(16'h01DD, 8'h60); push_wr(16'h01DC, 8'h00); push_wr(16'h01DB, 8'h20);
    push_ld(16'hABCD, 2'b01);
    insn_boundary = 1'b1;
    run_seq(6, 0, "nmi_after_brk");
`endif

    // Stack wrap, then async reset in VEC_LO aborts the IRQ.
    s_in = 8'h01; pch_in = 8'h77; pcl_in = 8'h88; p_in = 8'h20; irq_n = 1'b0;
    push_wr(16'h0101, 8'h77); push_wr(16'h0100, 8'h88); push_wr(16'h01FF, 8'h20);
    insn_boundary = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      insn_boundary = 1'b0;
    end
    irq_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.seq_busy}, 32'd1);
    chk("arst_addr", {16'd0, bus.mem_addr}, 32'h0000FFFC);
    chk("arst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("arst_pulses", {28'd0, s_dec, pc_ld, set_i, irq_ack}, 32'd0);
    chk("arst_pc_val", {16'd0, pc_val}, 32'd0);
    @(posedge clk); #1;
    chk("arst_hold_addr", {16'd0, bus.mem_addr}, 32'h0000FFFC);
    rst_n = 1'b1;
    push_ld(16'h1234, 2'b00);
    run_seq(3, 0, "reset2");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
